// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with one-word lines.
// A tag match answers the fetch in the same cycle. A miss fetches one word from
// memory, fills the line, and then returns to IDLE.
// Optional feature: define ICACHE_STATS_EN to add the saturating hit_count and
// miss_count outputs.
module icache_direct #(
  parameter int  NUM_SETS = 16,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int TAG_W    = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic [31:0] iload
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]  tag_arr  [NUM_SETS];
  logic [31:0]       data_arr [NUM_SETS];
  logic [29:0]       miss_q;             // word address of the line being filled

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              start_miss;
  logic              fill;
  logic              unused_byte_off;

  assign req_idx         = imemaddr[IDX_W+1:2];
  assign req_tag         = imemaddr[31:IDX_W+2];
  assign fill_idx        = miss_q[IDX_W-1:0];
  assign fill_tag        = miss_q[29:IDX_W];
  assign unused_byte_off = ^imemaddr[1:0];

  // A hit is only possible in IDLE, and flush masks it.
  assign hit = (state_q == IDLE) && imemREN && !flush && valid_q[req_idx] &&
               (tag_arr[req_idx] == req_tag);

  // A miss is started only from IDLE. Flush forces IDLE, so it blocks a new miss.
  assign start_miss = (state_q == IDLE) && imemREN && !hit && !flush;

  // Fill completes when memory delivers data, unless a flush discards it.
  assign fill = (state_q == FETCH) && !iwait && !flush;

  // State, valid bits and miss address, all with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_miss) miss_q <= imemaddr[31:2];
      if (flush)     valid_q <= '0;
      else if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays. The valid bits guard their contents.
  // NOTE: the arrays carry no reset; they only need valid bits cleared, which keeps them RAM-friendly.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

  // Next state: a miss enters FETCH, memory ready returns to IDLE, flush overrides both.
  always_comb begin
    // NOTE: default assignment first so that no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_miss) state_d = FETCH;
      FETCH:   if (!iwait)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs: hit data in IDLE, memory request in FETCH.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data_arr[req_idx] : 32'h0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_q, 2'b00};
      end
      default: ;
    endcase
  end

`ifdef ICACHE_STATS_EN
  // Saturating statistics counters. Reset clears them; flush leaves them unchanged.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF))        hit_count  <= hit_count + 32'd1;
      if (start_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed, table-driven bench for icache_direct (NUM_SETS=16).
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  icache_direct #(.NUM_SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .iload(iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        iwait;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ren, input logic [31:0] addr, input logic fl,
                     input logic iw, input logic [31:0] ld, input logic eh,
                     input logic [31:0] el, input logic er, input logic [31:0] ea);
    vec_t v;
    v.ren = ren; v.addr = addr; v.flush = fl; v.iwait = iw; v.iload = ld;
    v.ihit = eh; v.load = el; v.iren = er; v.iaddr = ea;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic eh, input logic [31:0] el,
                               input logic er, input logic [31:0] ea);
    check({tag, " ihit"},     {31'd0, ihit}, {31'd0, eh});
    check({tag, " imemload"}, imemload,      el);
    check({tag, " iREN"},     {31'd0, iREN}, {31'd0, er});
    check({tag, " iaddr"},    iaddr,         ea);
  endtask

  localparam logic [31:0] W40  = 32'h8C22_0004;
  localparam logic [31:0] W80  = 32'h1111_1111;
  localparam logic [31:0] W44  = 32'h2222_2222;
  localparam logic [31:0] W100 = 32'h3333_3333;

  initial begin
    // Each row is one clock cycle: inputs, then expected outputs in that cycle.
    //   ren addr          fl iw iload    ihit load  iren iaddr
    // Cold miss on 0x40 with two wait cycles.
    add(1, 32'h40,  0, 1, 32'h0, 0, 32'h0, 0, 32'h0);   // 0 IDLE miss
    add(1, 32'h40,  0, 1, 32'h0, 0, 32'h0, 1, 32'h40);  // 1 FETCH wait
    add(1, 32'h40,  0, 1, 32'h0, 0, 32'h0, 1, 32'h40);  // 2 FETCH wait
    add(1, 32'h40,  0, 0, W40,   0, 32'h0, 1, 32'h40);  // 3 FETCH data
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 4 hit
    // Warm hits, including the byte-offset alias.
    add(1, 32'h42,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 5
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 6
    // Conflict on index 0.
    add(1, 32'h80,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 7 miss
    add(1, 32'h80,  0, 0, W80,   0, 32'h0, 1, 32'h80);  // 8 fill
    add(1, 32'h80,  0, 0, 32'h0, 1, W80,   0, 32'h0);   // 9 hit
    add(1, 32'h40,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 10 evicted
    add(1, 32'h40,  0, 0, W40,   0, 32'h0, 1, 32'h40);  // 11
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 12
    add(1, 32'h44,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 13 index 1 miss
    add(1, 32'h44,  0, 0, W44,   0, 32'h0, 1, 32'h44);  // 14
    add(1, 32'h44,  0, 0, 32'h0, 1, W44,   0, 32'h0);   // 15
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 16 index 0 intact
    // Flush on the second FETCH cycle, coinciding with fill completion.
    add(1, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 17 miss
    add(1, 32'h100, 0, 1, 32'h0, 0, 32'h0, 1, 32'h100); // 18
    add(1, 32'h100, 1, 0, W100,  0, 32'h0, 1, 32'h100); // 19 flush wins
    add(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 20 back in IDLE
    add(1, 32'h40,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 21 0x40 flushed
    add(1, 32'h40,  0, 0, W40,   0, 32'h0, 1, 32'h40);  // 22
    add(1, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 23 0x100 never written
    add(1, 32'h100, 0, 0, W100,  0, 32'h0, 1, 32'h100); // 24
    add(1, 32'h100, 0, 0, 32'h0, 1, W100,  0, 32'h0);   // 25
    add(1, 32'h40,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 26 conflict
    add(1, 32'h40,  0, 0, W40,   0, 32'h0, 1, 32'h40);  // 27
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 28
    // Flush during a would-be hit masks ihit and invalidates the line.
    add(1, 32'h40,  1, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 29
    add(1, 32'h40,  0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   // 30 miss
    add(1, 32'h40,  0, 0, W40,   0, 32'h0, 1, 32'h40);  // 31
    add(1, 32'h40,  0, 0, 32'h0, 1, W40,   0, 32'h0);   // 32

    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b0; iload = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_outputs("reset", 0, 32'h0, 0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("reset hit_count",  hit_count,  32'd0);
    check("reset miss_count", miss_count, 32'd0);
`endif
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
`ifdef ICACHE_STATS_EN
      if (i == 7) begin
        check("stats hit_count",  hit_count,  32'd3);
        check("stats miss_count", miss_count, 32'd1);
      end
`endif
      imemREN = vecs[i].ren; imemaddr = vecs[i].addr; flush = vecs[i].flush;
      iwait = vecs[i].iwait; iload = vecs[i].iload;
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].ihit, vecs[i].load, vecs[i].iren, vecs[i].iaddr);
    end

    // No request: random addresses must neither hit nor start a miss.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      imemREN = 1'b0; imemaddr = $urandom; flush = 1'b0; iwait = 1'b0;
      #1;
      check($sformatf("idle%0d ihit", i), {31'd0, ihit}, 32'd0);
      check($sformatf("idle%0d iREN", i), {31'd0, iREN}, 32'd0);
    end

    // Reset during FETCH: the fill is dropped and all lines are invalid afterwards.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    #1 check("rst miss ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK);
    check("rst fetch iREN", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; imemaddr = 32'h40;
    #1;
    check_outputs("post-rst", 0, 32'h0, 0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("post-rst hit_count",  hit_count,  32'd0);
    check("post-rst miss_count", miss_count, 32'd0);
`endif
    @(negedge CLK);
    imemREN = 1'b0; iwait = 1'b0; iload = W40;
    #1 check_outputs("post-rst fetch", 0, 32'h0, 1, 32'h40);
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache that answers the datapath's instruction-fetch requests on the datapath-cache interface. It returns the instruction and a same-cycle hit on a tag match. On a miss it fetches one word from memory through the cache-control side and fills the line. It sits between the datapath fetch port and the memory controller's instruction port.

Parameters:
NUM_SETS, 16, number of one-word lines; power of 2, minimum 2.
IDX_W, $clog2(NUM_SETS), index width (derived; do not override).
TAG_W, 30-IDX_W, tag width (derived).

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
imemREN  in  1  datapath instruction read request
imemaddr  in  32  datapath fetch byte address
ihit  out  1  requested word valid this cycle
imemload  out  32  instruction word
flush  in  1  invalidate all lines
iREN  out  1  memory read request
iaddr  out  32  memory word address
iwait  in  1  memory busy; data valid when iREN=1 and iwait=0
iload  in  32  memory read data

Behaviour:
- Address split: [1:0] byte offset (ignored), [IDX_W+1:2] index, [31:IDX_W+2] tag.
- Storage per line: valid bit, TAG_W tag, 32-bit data.
- Reset (nRST=0 at edge): all valid bits cleared, state IDLE, miss address cleared. Outputs are ihit=0, imemload=0, iREN=0, iaddr=0. Data and tag arrays need not be reset.
- States: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==addr tag). ihit=hit, combinational, zero latency.
  - imemload = data[idx] when hit, else 0.
  - iREN=0.
  - imemREN & !hit -> latch {tag,idx,2'b00} as miss address; go to FETCH next edge.
- FETCH:
  - iREN=1, iaddr=latched miss address, ihit=0, imemload=0.
  - iwait=1 -> stay in FETCH.
  - iwait=0 -> at that edge write data=iload, tag, valid=1 into the latched index; go to IDLE.
  - Next cycle a fetch of the same address hits.
  - Miss penalty = (iwait-high cycles) + 2 cycles until ihit.
- A fill is never cancelled by imemREN falling or imemaddr changing; it completes for the latched address. The new address is evaluated in IDLE afterwards.
- flush=1 (any state): all valid bits cleared at the edge; state forced to IDLE; an in-progress fill is discarded (no line written). ihit is forced 0 while flush=1.
- Flush vs fill: flush and fill-completion in the same cycle resolve to flush; the line stays invalid.
- Reset vs flush: reset has priority over flush.
- imemREN=0: ihit=0 and no miss is started.
- Array write and read of the same index in the same cycle: the read sees the old contents; the new line is visible next cycle.

Optional Feature:
Macro: ICACHE_STATS_EN.
- Defined: adds outputs hit_count (out, 32) and miss_count (out, 32).
  - hit_count increments every cycle ihit=1; a stalled fetch counts repeatedly.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFFFFFF.
  - Both cleared by reset; unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Cold miss. After reset, imemREN=1, imemaddr=0x00000040; memory holds iwait=1 for 2 cycles, then iwait=0 with iload=0x8C220004. Expect iREN=1 for 3 cycles with iaddr=0x40, ihit=0 throughout. The following cycle gives ihit=1, imemload=0x8C220004.
2. Warm hit. Same address again: ihit=1 in the same cycle, imemload=0x8C220004, iREN never asserted. Also 0x42 (byte offset set) hits the same line.
3. Conflict, NUM_SETS=16.
   - Fill 0x40, then read 0x80 (same index 0, tag 2): miss; iaddr=0x80.
   - Re-read 0x40: miss again, iaddr=0x40.
   - Re-read 0x44 (index 1) after its own fill: hit.
4. Flush mid-fill. Start miss on 0x100; assert flush on the second FETCH cycle. Expect iREN=0 next cycle and state IDLE. A later read of 0x100 misses, and the previously cached 0x40 also misses.
5. No request / reset.
   - imemREN=0 for 10 cycles with a random address: ihit=0, iREN=0.
   - Assert nRST=0 during FETCH: next cycle iREN=0, and all lines miss.
6. ICACHE_STATS_EN: after scenarios 1–2 (with fetch held 1 cycle each), expect miss_count=1 and hit_count=3; both read 0 after reset.
